// File: rtl/sisc_ctrl_pkg.sv
// Shared constants for the SISC multi-cycle controller: opcodes, FSM state
// encoding, status-register bit positions and small decode helpers.
package sisc_ctrl_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ALU_RR  = 4'h1;
  localparam logic [3:0] OP_ALU_IMM = 4'h2;
  localparam logic [3:0] OP_LOAD    = 4'h3;
  localparam logic [3:0] OP_STORE   = 4'h4;
  localparam logic [3:0] OP_BRA     = 4'h5;
  localparam logic [3:0] OP_BRR     = 4'h6;
  localparam logic [3:0] OP_BNE     = 4'h7;
  localparam logic [3:0] OP_HALT    = 4'hF;

  // stat = {C,V,N,Z}
  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;
  localparam int ST_C = 3;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ALU_RR) || (op == OP_ALU_IMM);
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BRA) || (op == OP_BRR) || (op == OP_BNE);
  endfunction

  // BRA/BRR take on any masked flag set; BNE takes when none are set.
  function automatic logic br_taken(input logic [3:0] op, input logic [3:0] mm,
                                    input logic [3:0] stat);
    logic hit;
    hit = (mm[ST_C] & stat[ST_C]) | (mm[ST_V] & stat[ST_V]) |
          (mm[ST_N] & stat[ST_N]) | (mm[ST_Z] & stat[ST_Z]);
    return (op == OP_BNE) ? !hit : hit;
  endfunction

endpackage

// File: rtl/sisc_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side,
// slave = datapath side.
interface sisc_ctrl_if #(parameter int CNT_W = 16);
  logic [3:0]       opcode;
  logic [3:0]       mm;
  logic [3:0]       stat;
  logic             mem_ready;
  logic             pc_rst;
  logic             pc_write;
  logic             pc_sel;
  logic             br_sel;
  logic             ir_load;
  logic             alu_src;
  logic             stat_en;
  logic             mem_req;
  logic             mem_we;
  logic             wb_sel;
  logic             rf_we;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, mm, stat, mem_ready,
    output pc_rst, pc_write, pc_sel, br_sel, ir_load, alu_src, stat_en,
           mem_req, mem_we, wb_sel, rf_we, halted, mem_err, instr_cnt
  );

  modport slave (
    output opcode, mm, stat, mem_ready,
    input  pc_rst, pc_write, pc_sel, br_sel, ir_load, alu_src, stat_en,
           mem_req, mem_we, wb_sel, rf_we, halted, mem_err, instr_cnt
  );
endinterface

// File: rtl/sisc_ctrl_wait_timer.sv
// Counts MEM cycles spent without mem_ready; flags the cycle in which the
// MAX-th consecutive not-ready MEM cycle occurs.
module sisc_ctrl_wait_timer #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic in_mem,
  input  logic ready,
  output logic expired
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  // Held at zero outside MEM, so every MEM visit starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst || !in_mem) cnt <= '0;
    else if (!ready)    cnt <= cnt + 1'b1;
  end

  // ready has priority: a response on the limit cycle is still accepted.
  assign expired = in_mem && !ready && (cnt == W'(MAX - 1));

endmodule

// File: rtl/sisc_ctrl.sv
// SISC multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing,
// Moore strobe decode, memory timeout handling and retired-instruction count.
module sisc_ctrl
  import sisc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  sisc_ctrl_if.master  bus
);

  state_e           state;
  logic [3:0]       op_q;
  logic [3:0]       mm_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             in_mem;
  logic             timeout;

  assign in_mem = (state == S_MEM);

  sisc_ctrl_wait_timer #(.MAX(MEM_WAIT_MAX)) u_wait (
    .clk     (clk),
    .rst     (rst),
    .in_mem  (in_mem),
    .ready   (bus.mem_ready),
    .expired (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
      op_q  <= '0;
      mm_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          op_q  <= bus.opcode;
          mm_q  <= bus.mm;
          state <= (bus.opcode == OP_HALT) ? S_HALT : S_EXECUTE;
        end
        S_EXECUTE: begin
          if (is_mem(op_q))      state <= S_MEM;
          else if (is_alu(op_q)) state <= S_WRITEBACK;
          else begin
            state <= S_FETCH;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (op_q == OP_LOAD) state <= S_WRITEBACK;
            else begin
              state <= S_FETCH;
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (timeout) begin
            state <= S_HALT;
            err_q <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          state <= S_FETCH;
          cnt_q <= cnt_q + 1'b1;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  // Strobes are pure functions of the state register plus latched IR fields;
  // only the branch decision looks at live stat, sampled during EXECUTE.
  always_comb begin
    bus.pc_rst   = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.br_sel   = 1'b0;
    bus.ir_load  = 1'b0;
    bus.alu_src  = 1'b0;
    bus.stat_en  = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.wb_sel   = 1'b1;
    bus.rf_we    = 1'b0;
    bus.halted   = 1'b0;
    case (state)
      S_RESET: bus.pc_rst = 1'b1;
      S_FETCH: begin
        bus.ir_load  = 1'b1;
        bus.pc_write = 1'b1;
      end
      S_EXECUTE: begin
        if (is_alu(op_q)) begin
          bus.stat_en = 1'b1;
          bus.alu_src = (op_q == OP_ALU_IMM);
        end
        if (is_branch(op_q)) begin
          bus.br_sel = (op_q == OP_BRR);
          if (br_taken(op_q, mm_q, bus.stat)) begin
            bus.pc_write = 1'b1;
            bus.pc_sel   = 1'b1;
          end
        end
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (op_q == OP_STORE);
        bus.wb_sel  = (op_q != OP_LOAD);
      end
      S_WRITEBACK: begin
        bus.rf_we  = 1'b1;
        bus.wb_sel = (op_q != OP_LOAD);
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_err   = err_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_sisc_ctrl.sv
// Scoreboard bench for sisc_ctrl: per-cycle expected strobes and counts are
// queued as each instruction is issued, then popped against the DUT.
module tb_sisc_ctrl;

  localparam logic [12:0] PCR = 13'h1000, PCW = 13'h0800, PCS = 13'h0400,
                          BRS = 13'h0200, IRL = 13'h0100, ALS = 13'h0080,
                          STE = 13'h0040, MRQ = 13'h0020, MWE = 13'h0010,
                          WBS = 13'h0008, RFW = 13'h0004, HLT = 13'h0002,
                          MER = 13'h0001;
  localparam int WAIT_MAX = 15;

  typedef struct {
    logic [23:0] tag;
    logic [12:0] o;
    logic [15:0] cnt;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w_rst = 1'b1;
  always #5 clk = ~clk;

  sisc_ctrl_if #(.CNT_W(16)) bus ();
  sisc_ctrl_if #(.CNT_W(4))  wbus ();

  sisc_ctrl #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  sisc_ctrl #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut_w (
    .clk (clk), .rst (w_rst), .bus (wbus)
  );

  logic [12:0] obs;
  assign obs = {bus.pc_rst, bus.pc_write, bus.pc_sel, bus.br_sel, bus.ir_load,
                bus.alu_src, bus.stat_en, bus.mem_req, bus.mem_we, bus.wb_sel,
                bus.rf_we, bus.halted, bus.mem_err};

  exp_t        sb[$];
  logic [15:0] mcnt = '0;
  bit          merr = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic push(input logic [23:0] tag, input logic [12:0] o, input logic rdy);
    exp_t e;
    e.tag = tag; e.o = o; e.cnt = mcnt; e.rdy = rdy;
    sb.push_back(e);
  endtask

  // Entered and left at posedge+1; one queue entry per clock cycle.
  task automatic run();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.mem_ready = e.rdy;
      @(negedge clk);
      chk($sformatf("%s/outs", e.tag), 32'(obs), 32'(e.o));
      chk($sformatf("%s/cnt", e.tag), 32'(bus.instr_cnt), 32'(e.cnt));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
    mcnt = '0;
    merr = 0;
    push("RST", PCR | WBS, 1'b0);
    run();
  endtask

  // rdy_at: MEM cycle (1-based) in which mem_ready is raised; 0 = never.
  task automatic issue(input logic [3:0] op, input logic [3:0] m,
                       input logic [3:0] st, input int rdy_at);
    logic [12:0] eo;
    bit ld, alu, taken, done;
    ld  = (op == 4'h3);
    alu = (op == 4'h1) || (op == 4'h2);
    bus.opcode = op; bus.mm = m; bus.stat = st;
    push("F", WBS | IRL | PCW, 1'b0);
    push("D", WBS, 1'b0);
    if (op == 4'hF) begin
      repeat (12) push("H", WBS | HLT | (merr ? MER : 13'h0), 1'b0);
      run();
      return;
    end
    eo = WBS;
    if (alu) eo |= STE | ((op == 4'h2) ? ALS : 13'h0);
    if (op == 4'h5 || op == 4'h6 || op == 4'h7) begin
      if (op == 4'h7) taken = ((m & st) == 4'h0);
      else            taken = ((m & st) != 4'h0);
      if (op == 4'h6) eo |= BRS;
      if (taken)      eo |= PCW | PCS;
    end
    push("E", eo, 1'b0);
    if (ld || op == 4'h4) begin
      done = 0;
      for (int k = 1; k <= WAIT_MAX && !done; k++) begin
        done = (k == rdy_at);
        push("M", MRQ | ((op == 4'h4) ? MWE : 13'h0) | (ld ? 13'h0 : WBS), done);
      end
      if (!done) begin
        merr = 1;
        repeat (12) push("TO", WBS | HLT | MER, 1'b0);
        run();
        return;
      end
    end
    if (ld || alu) push("W", RFW | (ld ? 13'h0 : WBS), 1'b0);
    run();
    mcnt++;
  endtask

  initial begin
    bus.opcode = '0; bus.mm = '0; bus.stat = '0; bus.mem_ready = 1'b0;
    wbus.opcode = '0; wbus.mm = '0; wbus.stat = '0; wbus.mem_ready = 1'b0;

    do_reset(2);
    issue(4'h1, 4'h0, 4'h0, 0);   // ALU_RR
    issue(4'h2, 4'h0, 4'h0, 0);   // ALU_IMM
    issue(4'h3, 4'h0, 4'h0, 3);   // LOAD, ready on 3rd MEM cycle
    issue(4'h4, 4'h0, 4'h0, 1);   // STORE, immediate ready
    issue(4'h5, 4'h1, 4'h1, 0);   // BRA taken
    issue(4'h7, 4'h1, 4'h1, 0);   // BNE not taken
    issue(4'h6, 4'h4, 4'h6, 0);   // BRR taken
    issue(4'h5, 4'h2, 4'h1, 0);   // BRA not taken
    issue(4'h7, 4'h8, 4'h7, 0);   // BNE taken
    issue(4'h0, 4'h0, 4'h0, 0);   // NOP
    issue(4'h9, 4'hF, 4'hF, 0);   // undefined -> NOP
    issue(4'h3, 4'h0, 4'h0, WAIT_MAX); // ready on the limit cycle wins
    issue(4'h4, 4'h0, 4'h0, 0);   // STORE timeout -> HALT + mem_err

    do_reset(1);
    issue(4'h1, 4'h0, 4'h0, 0);
    issue(4'h3, 4'h0, 4'h0, 1);
    issue(4'hF, 4'h0, 4'h0, 0);   // HALT held
    do_reset(1);

    // 4-bit counter instance runs back-to-back NOPs (RESET, then F/D/E x N).
    w_rst = 1'b0;
    repeat (46) @(posedge clk);
    @(negedge clk);
    chk("wrap/fetch15", 32'(wbus.ir_load), 32'd1);
    chk("wrap/cnt15", 32'(wbus.instr_cnt), 32'd15);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wrap/fetch16", 32'(wbus.ir_load), 32'd1);
    chk("wrap/cnt16", 32'(wbus.instr_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sisc_ctrl.md
Name: sisc_ctrl

Overview:
Multi-cycle control unit for the SISC processor. It sequences fetch, decode, execute, memory and writeback. It drives the PC, IR, register-file and data-memory strobes. It also drives wb_sel into the 32-bit writeback mux, where 0 selects memory read data and 1 selects the ALU result. It handles the data-memory request/ready handshake, with a timeout, and counts retired instructions.

Parameters:
MEM_WAIT_MAX, 15, maximum cycles spent in MEM without mem_ready before the abort to HALT.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
opcode  input  4  IR[31:28]; stable from DECODE until the next FETCH
mm  input  4  IR[27:24]; branch condition mask
stat  input  4  status register {C,V,N,Z}
mem_ready  input  1  data memory has completed the current request
pc_rst  output  1  clear the PC
pc_write  output  1  load the PC
pc_sel  output  1  0 = PC+1, 1 = branch target
br_sel  output  1  branch target base: 0 = absolute, 1 = PC-relative
ir_load  output  1  load the IR
alu_src  output  1  ALU operand B: 0 = register, 1 = immediate
stat_en  output  1  update the status register
mem_req  output  1  data memory request
mem_we  output  1  data memory write
wb_sel  output  1  writeback mux select: 0 = memory data, 1 = ALU result
rf_we  output  1  register-file write
halted  output  1  controller is in HALT
mem_err  output  1  sticky flag: memory timeout occurred
instr_cnt  output  CNT_W  count of retired instructions

Behaviour:
- Opcode set: 0x0 NOP, 0x1 ALU_RR, 0x2 ALU_IMM, 0x3 LOAD, 0x4 STORE, 0x5 BRA, 0x6 BRR, 0x7 BNE, 0xF HALT. Every other opcode executes as NOP.
- State register encoding: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6.
- In DECODE the controller latches opcode and mm into op_q and mm_q. All later decode uses op_q and mm_q.
- Transitions:
  - RESET -> FETCH.
  - FETCH -> DECODE.
  - DECODE -> HALT if opcode is HALT, otherwise EXECUTE.
  - EXECUTE -> MEM for LOAD and STORE; -> WRITEBACK for ALU_RR and ALU_IMM; -> FETCH for all others.
  - MEM waits for mem_ready = 1, then goes to WRITEBACK for LOAD or FETCH for STORE.
  - WRITEBACK -> FETCH.
  - HALT holds until rst.
- Outputs are Moore, decoded from state, op_q and mm_q. Any output not listed for a state is 0.
  - RESET: pc_rst = 1.
  - FETCH: ir_load = 1, pc_write = 1, pc_sel = 0.
  - EXECUTE with an ALU op: stat_en = 1; alu_src = 1 only for ALU_IMM.
  - EXECUTE with a branch: branch is taken when (mm_q & stat) != 0 for BRA and BRR, or when (mm_q & stat) == 0 for BNE. If taken, pc_write = 1 and pc_sel = 1. br_sel = 1 for BRR only. stat is sampled in the EXECUTE cycle.
  - MEM: mem_req = 1. mem_we = 1 only for STORE.
  - WRITEBACK: rf_we = 1.
  - HALT: halted = 1.
- wb_sel is 0 in MEM and WRITEBACK when op_q is LOAD, and 1 in every other state, including RESET.
- Latency from FETCH entry to the next FETCH:
  - NOP and branches: 3 cycles.
  - ALU ops: 4 cycles.
  - STORE: 4 cycles plus memory wait cycles.
  - LOAD: 5 cycles plus memory wait cycles.
- Memory wait counter:
  - Clears on MEM entry and increments each MEM cycle while mem_ready = 0.
  - If it reaches MEM_WAIT_MAX with mem_ready still 0, the next state is HALT and mem_err is set. No rf_we is issued.
  - If mem_ready = 1 in the same cycle the count reaches MEM_WAIT_MAX, mem_ready wins.
- instr_cnt increments by 1 on every transition into FETCH from EXECUTE, MEM or WRITEBACK. It wraps modulo 2^CNT_W. It does not increment on RESET -> FETCH or on entry to HALT.
- Reset values: state = RESET, op_q = 0, mm_q = 0, wait counter = 0, instr_cnt = 0, mem_err = 0. In the RESET state, pc_rst = 1 and wb_sel = 1; all other outputs are 0.
- rst asserted in any state, including mid-MEM, takes effect at the next edge. The pending memory request is dropped: mem_req is 0 from that edge onward.

Decomposition:
- Package sisc_ctrl_pkg holds the opcode constants, the state encoding and the status bit indices.
- The memory wait/timeout counter is the only natural sub-module: sisc_ctrl_wait_timer.
- The main FSM, output decode and instr_cnt stay in sisc_ctrl.

Test Plan:
- rst high for 2 cycles, then low -> pc_rst = 1 in cycle 1 after reset release, ir_load = 1 in cycle 2, instr_cnt = 0, wb_sel = 1.
- ALU_RR (0x1) -> states F, D, E, W; stat_en = 1 in E; rf_we = 1 and wb_sel = 1 in W; instr_cnt becomes 1 after 4 cycles.
- LOAD (0x3) with mem_ready asserted on the 3rd MEM cycle -> mem_req high for 3 cycles; wb_sel = 0 in MEM and WB; rf_we pulses once.
- BRA with mm = 0001 and stat = 0001 -> pc_write = 1, pc_sel = 1, br_sel = 0 in EXECUTE. BNE with the same mm and stat -> pc_write = 0 in EXECUTE.
- STORE with mem_ready held at 0 and MEM_WAIT_MAX = 15 -> mem_err = 1 and halted = 1 after 15 MEM cycles; mem_we was high during MEM; no rf_we.
- HALT (0xF) -> halted held for more than 10 cycles. Then rst for 1 cycle -> halted = 0, mem_err = 0, instr_cnt = 0. Separately, preload CNT_W = 4 and retire 16 instructions -> instr_cnt wraps to 0.
